// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX/MEM pipeline register with a one-entry skid buffer and branch/jump redirect.
// Define EX_MEM_STALL_CNT_EN to count backpressure cycles on stall_cnt_out.
module ex_mem_pipe_reg #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [6:0]                 ctrl_in,
    input  logic                       zero_in,
    input  logic [XLEN-1:0]            alu_result_in,
    input  logic [XLEN-1:0]            rd2_in,
    input  logic [RA_W-1:0]            wn_in,
    input  logic [XLEN-1:0]            b_address_in,
    input  logic [XLEN-1:0]            j_address_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4+2*XLEN+RA_W-1:0]   payload_out,
    output logic                       redirect_out,
    output logic [XLEN-1:0]            redirect_pc_out,
    output logic [31:0]                stall_cnt_out
);
    // ctrl = {wb[1:0], branch, mem_read, mem_write, beq_bne, jump}
    typedef struct packed {
        logic [6:0]      ctrl;
        logic            zero;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rd2;
        logic [RA_W-1:0] wn;
        logic [XLEN-1:0] b_addr;
        logic [XLEN-1:0] j_addr;
    } entry_t;

    entry_t in_e, main_q, main_d, skid_q, skid_d;
    logic   main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic   accept, load_main, taken;

    assign in_e      = {ctrl_in, zero_in, alu_result_in, rd2_in, wn_in, b_address_in, j_address_in};
    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign accept    = in_valid & in_ready;
    assign load_main = ~main_v_q | out_ready;

    always_comb begin
        main_d   = load_main ? (skid_v_q ? skid_q : (accept ? in_e : main_q)) : main_q;
        skid_d   = (~load_main & accept) ? in_e : skid_q;
        main_v_d = ~flush & (load_main ? (skid_v_q | accept) : main_v_q);
        skid_v_d = ~flush & ~load_main & (skid_v_q | accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign payload_out     = {main_q.ctrl[6:5], main_q.ctrl[3], main_q.ctrl[2], main_q.alu, main_q.rd2, main_q.wn};
    assign taken           = main_q.ctrl[0] | (main_q.ctrl[4] & (main_q.ctrl[1] ? ~main_q.zero : main_q.zero));
    assign redirect_out    = main_v_q & taken;
    assign redirect_pc_out = redirect_out ? (main_q.ctrl[0] ? main_q.j_addr : main_q.b_addr) : '0;

`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (main_v_q & ~out_ready & ~&stall_cnt_q)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt_out = stall_cnt_q;
`else
    assign stall_cnt_out = 32'd0;
`endif
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: directed self-checking bench for ex_mem_pipe_reg.
module tb_ex_mem_pipe_reg;
    localparam int XLEN = 32;
    localparam int RA_W = 5;
    localparam int PW   = 4 + 2*XLEN + RA_W;

    logic            clk, rst, flush, in_valid, in_ready, zero_in, out_valid, out_ready, redirect_out;
    logic [6:0]      ctrl_in;
    logic [XLEN-1:0] alu_result_in, rd2_in, b_address_in, j_address_in, redirect_pc_out;
    logic [RA_W-1:0] wn_in;
    logic [PW-1:0]   payload_out;
    logic [31:0]     stall_cnt_out;
    int              n_tests, n_fail;
    logic [127:0]    pa, pb, pe;

    ex_mem_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_in(ctrl_in), .zero_in(zero_in), .alu_result_in(alu_result_in), .rd2_in(rd2_in),
        .wn_in(wn_in), .b_address_in(b_address_in), .j_address_in(j_address_in),
        .out_valid(out_valid), .out_ready(out_ready), .payload_out(payload_out),
        .redirect_out(redirect_out), .redirect_pc_out(redirect_pc_out), .stall_cnt_out(stall_cnt_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] c, input logic z, input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rd2,
                         input logic [RA_W-1:0] wn, input logic [XLEN-1:0] ba, input logic [XLEN-1:0] ja);
        in_valid = 1'b1; ctrl_in = c; zero_in = z; alu_result_in = alu; rd2_in = rd2;
        wn_in = wn; b_address_in = ba; j_address_in = ja;
    endtask

    function automatic logic [127:0] exp_pl(input logic [6:0] c, input logic [XLEN-1:0] alu,
                                            input logic [XLEN-1:0] rd2, input logic [RA_W-1:0] wn);
        logic [PW-1:0] p;
        p = {c[6:5], c[3], c[2], alu, rd2, wn};
        return 128'(p);
    endfunction

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ctrl_in = '0; zero_in = 1'b0; alu_result_in = '0; rd2_in = '0; wn_in = '0;
        b_address_in = '0; j_address_in = '0;
        step(); step();
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_redirect", 128'(redirect_out), 128'd0);
        check("rst_redirect_pc", 128'(redirect_pc_out), 128'd0);
        check("rst_stall_cnt", 128'(stall_cnt_out), 128'd0);
        check("rst_payload", 128'(payload_out), 128'd0);
        rst = 1'b0;

        // streaming four entries with out_ready high
        for (int i = 0; i < 4; i++) begin
            drive(7'h68, 1'b0, 32'h10 + i, 32'h20 + i, 5'(i + 1), 32'h0, 32'h0);
            step();
            check($sformatf("stream_valid%0d", i), 128'(out_valid), 128'd1);
            check($sformatf("stream_payload%0d", i), 128'(payload_out), exp_pl(7'h68, 32'h10 + i, 32'h20 + i, 5'(i + 1)));
            check($sformatf("stream_ready%0d", i), 128'(in_ready), 128'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain", 128'(out_valid), 128'd0);

        // backpressure: A held, B in skid, C refused
        out_ready = 1'b0;
        pa = exp_pl(7'h44, 32'hAAAA_0001, 32'h1111, 5'd3);
        pb = exp_pl(7'h24, 32'hBBBB_0002, 32'h2222, 5'd4);
        drive(7'h44, 1'b0, 32'hAAAA_0001, 32'h1111, 5'd3, 32'h0, 32'h0);
        step();
        check("bp_a_valid", 128'(out_valid), 128'd1);
        check("bp_a_payload", 128'(payload_out), pa);
        check("bp_a_ready", 128'(in_ready), 128'd1);
        drive(7'h24, 1'b0, 32'hBBBB_0002, 32'h2222, 5'd4, 32'h0, 32'h0);
        step();
        check("bp_b_hold_a", 128'(payload_out), pa);
        check("bp_b_ready", 128'(in_ready), 128'd0);
        drive(7'h48, 1'b0, 32'hCCCC_0003, 32'h3333, 5'd5, 32'h0, 32'h0);
        step();
        check("bp_c_hold_a", 128'(payload_out), pa);
        check("bp_c_ready", 128'(in_ready), 128'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("bp_b_valid", 128'(out_valid), 128'd1);
        check("bp_b_payload", 128'(payload_out), pb);
        check("bp_b_ready_up", 128'(in_ready), 128'd1);
        step();
        check("bp_c_dropped", 128'(out_valid), 128'd0);

        // redirect decode: not taken, beq taken, bne taken, jump priority, then idle
        drive(7'h10, 1'b0, 32'h1, 32'h0, 5'd0, 32'h0000_0200, 32'h0000_0300);
        step();
        check("br_nt_redirect", 128'(redirect_out), 128'd0);
        check("br_nt_pc", 128'(redirect_pc_out), 128'd0);
        drive(7'h10, 1'b1, 32'h2, 32'h0, 5'd0, 32'h0000_0080, 32'h0000_0300);
        step();
        check("beq_redirect", 128'(redirect_out), 128'd1);
        check("beq_pc", 128'(redirect_pc_out), 128'h80);
        drive(7'h12, 1'b0, 32'h3, 32'h0, 5'd0, 32'h0000_0040, 32'h0000_0999);
        step();
        check("bne_redirect", 128'(redirect_out), 128'd1);
        check("bne_pc", 128'(redirect_pc_out), 128'h40);
        drive(7'h13, 1'b1, 32'h4, 32'h0, 5'd0, 32'h0000_0040, 32'h0000_0100);
        step();
        check("jump_redirect", 128'(redirect_out), 128'd1);
        check("jump_pc", 128'(redirect_pc_out), 128'h100);
        in_valid = 1'b0;
        step();
        check("idle_redirect", 128'(redirect_out), 128'd0);
        check("idle_pc", 128'(redirect_pc_out), 128'd0);

        // flush with both entries full and an input offered
        out_ready = 1'b0;
        drive(7'h40, 1'b0, 32'h51, 32'h0, 5'd1, 32'h0, 32'h0);
        step();
        drive(7'h40, 1'b0, 32'h52, 32'h0, 5'd2, 32'h0, 32'h0);
        step();
        check("fl_full_ready", 128'(in_ready), 128'd0);
        drive(7'h40, 1'b0, 32'h53, 32'h0, 5'd3, 32'h0, 32'h0);
        flush = 1'b1;
        step();
        check("fl_out_valid", 128'(out_valid), 128'd0);
        check("fl_in_ready", 128'(in_ready), 128'd1);
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("fl_input_dropped", 128'(out_valid), 128'd0);
        drive(7'h40, 1'b0, 32'h54, 32'h0, 5'd4, 32'h0, 32'h0);
        flush = 1'b1;
        step();
        check("fl_empty_drop", 128'(out_valid), 128'd0);
        flush = 1'b0; in_valid = 1'b0;

        // reset mid-transfer beats flush, then accept right after
        drive(7'h40, 1'b0, 32'h61, 32'h0, 5'd1, 32'h0, 32'h0);
        step();
        drive(7'h40, 1'b0, 32'h62, 32'h0, 5'd2, 32'h0, 32'h0);
        step();
        rst = 1'b1; flush = 1'b1;
        step();
        check("rst_mid_valid", 128'(out_valid), 128'd0);
        check("rst_mid_ready", 128'(in_ready), 128'd1);
        check("rst_mid_payload", 128'(payload_out), 128'd0);
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        pe = exp_pl(7'h6C, 32'h77, 32'h88, 5'd9);
        drive(7'h6C, 1'b0, 32'h77, 32'h88, 5'd9, 32'h0, 32'h0);
        step();
        check("post_rst_valid", 128'(out_valid), 128'd1);
        check("post_rst_payload", 128'(payload_out), pe);
        in_valid = 1'b0;
        step();

        // stall counter: five cycles of out_valid & ~out_ready after a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b0;
        drive(7'h40, 1'b0, 32'h99, 32'h0, 5'd1, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
`ifdef EX_MEM_STALL_CNT_EN
        check("stall_cnt", 128'(stall_cnt_out), 128'd5);
`else
        check("stall_cnt", 128'(stall_cnt_out), 128'd0);
`endif
        check("stall_hold_valid", 128'(out_valid), 128'd1);
        out_ready = 1'b1;
        step();
        check("stall_release", 128'(out_valid), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_mem_pipe_reg.md
EX_MEM_PIPE_REG -- requirements
Module: ex_mem_pipe_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath and address width.
REQ-002 SHALL have parameter RA_W, default 5: register-file write-address width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  in  1  discard all held and incoming entries.
REQ-006 SHALL have port in_valid  in  1  EX stage offers an entry.
REQ-007 SHALL have port in_ready  out  1  stage can accept; registered, equals NOT skid_valid.
REQ-008 SHALL have port ctrl_in  in  7  {wb[1:0], branch, mem_read, mem_write, beq_bne, jump}.
REQ-009 SHALL have port zero_in  in  1  ALU zero flag.
REQ-010 SHALL have port alu_result_in  in  XLEN  ALU result.
REQ-011 SHALL have port rd2_in  in  XLEN  store data.
REQ-012 SHALL have port wn_in  in  RA_W  destination register.
REQ-013 SHALL have port b_address_in  in  XLEN  branch target.
REQ-014 SHALL have port j_address_in  in  XLEN  jump target.
REQ-015 SHALL have port out_valid  out  1  MEM-side entry present.
REQ-016 SHALL have port out_ready  in  1  MEM stage accepts entry.
REQ-017 SHALL have port payload_out  out  4+2*XLEN+RA_W  {wb, mem_read, mem_write, alu_result, rd2, wn} of head entry.
REQ-018 SHALL have port redirect_out  out  1  head entry is a taken branch or jump.
REQ-019 SHALL have port redirect_pc_out  out  XLEN  redirect target.
REQ-020 SHALL have port stall_cnt_out  out  32  backpressure cycle count (see Configuration).

Function
REQ-021 SHALL hold two entries: main (drives outputs) and skid; each with a valid bit.
REQ-022 SHALL accept on in_valid & in_ready; transfer out on out_valid & out_ready.
REQ-023 SHALL load main from skid if skid valid, else from input, whenever main empty or transferring out.
REQ-024 SHALL write accepted entry to skid when main valid and not transferring out.
REQ-025 SHALL give latency 1 cycle input->out_valid when empty; throughput 1 entry/cycle with out_ready high.
REQ-026 SHALL keep payload_out stable while out_valid & ~out_ready.
REQ-027 SHALL compute taken = jump | (branch & (beq_bne ? ~zero : zero)) from main entry fields.
REQ-028 SHALL drive redirect_out = out_valid & taken, combinationally from main.
REQ-029 SHALL drive redirect_pc_out = jump ? j_address : b_address (jump has priority); 0 when redirect_out low.
REQ-030 SHALL on flush clear both valid bits next cycle, drop any same-cycle input, and raise in_ready next cycle.
REQ-031 SHALL give flush priority over accept and transfer; rst priority over flush.
REQ-032 SHALL never overflow: with skid full, in_ready low, input ignored.

Reset
REQ-033 SHALL on rst clear main/skid valid, all payload registers to 0, in_ready=1, out_valid=0, redirect_out=0, redirect_pc_out=0, stall_cnt_out=0.
REQ-034 SHALL on rst mid-transfer drop all entries; first accept allowed the cycle after rst deasserts.

Configuration
REQ-035 SHALL with EX_MEM_STALL_CNT_EN defined increment stall_cnt_out each cycle out_valid & ~out_ready, saturating at 0xFFFFFFFF, cleared by rst only.
REQ-036 SHALL without EX_MEM_STALL_CNT_EN tie stall_cnt_out to 0 and instantiate no counter.

Verification
REQ-037 SHALL cover streaming: in_valid=1 four cycles, out_ready=1 -> out_valid one cycle later, four entries in order, in_ready stays 1.
REQ-038 SHALL cover backpressure: out_ready=0, send A,B,C -> A held on payload_out, B in skid, in_ready=0, C not accepted; out_ready=1 -> A then B emitted.
REQ-039 SHALL cover redirect: ctrl beq_bne=1, branch=1, zero=0, b_address=0x40 -> redirect_out=1, redirect_pc_out=0x40; same with jump=1, j_address=0x100 -> 0x100.
REQ-040 SHALL cover flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, input dropped.
REQ-041 SHALL cover stall counter: with EX_MEM_STALL_CNT_EN, 5 cycles out_valid & ~out_ready -> stall_cnt_out=5; without macro -> 0.
